// File: rtl/mem_bus_responder_pkg.sv
// Shared types, constants and helpers for the memory bus responder.
// Used by mem_bus_responder; the optional feature macro is MEM_BUS_RESPONDER_BYTE_EN.
package mem_bus_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;

  // Low address bits that must be zero for a word access
  localparam logic [31:0] ADDR_OFFSET_MASK = 32'(WORD_BYTES - 1);

  // Misaligned or beyond the end of the store. There is no wrap-around:
  // any address at or above depth is rejected.
  function automatic logic is_bad_addr(input logic [31:0] addr, input logic [31:0] depth);
    return ((addr & ADDR_OFFSET_MASK) != 32'd0) || (addr >= depth);
  endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// Request/response bus between the core load/store path and the memory responder.
// The req_be lane-enable signal exists only when MEM_BUS_RESPONDER_BYTE_EN is defined.
//
// Handshake: a request transfers at a rising edge where req_valid && req_ready.
// The requester holds req_* stable until that edge; nothing is queued while
// req_ready is low. rsp_valid is a single-cycle pulse; rsp_rdata and rsp_err
// are meaningful only while rsp_valid is high and are 0 otherwise.
interface mem_bus_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
`ifdef MEM_BUS_RESPONDER_BYTE_EN
  logic [3:0]  req_be;
`endif
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

`ifdef MEM_BUS_RESPONDER_BYTE_EN
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
`else
  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
`endif
endinterface

// File: rtl/mem_bus_responder_byte_array.sv
// Four-lane byte RAM. Lane i holds byte i of every word (little-endian), so a
// word-aligned access touches one entry in each lane. Synchronous per-lane write,
// combinational read of the addressed word.
module mem_byte_array #(
  parameter int WORDS = 64,
  parameter int WIW   = 6
) (
  input  logic           clk,
  input  logic [WIW-1:0] word_idx,
  input  logic [3:0]     lane_we,
  input  logic [31:0]    wdata,
  output logic [31:0]    rdata
);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] lane_mem [WORDS];

    // Write the enabled lane at the clock edge; contents are never cleared
    always_ff @(posedge clk) begin
      if (lane_we[g]) lane_mem[word_idx] <= wdata[8*g +: 8];
    end

    assign rdata[8*g +: 8] = lane_mem[word_idx];
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Handshaked memory responder: one word request at a time, fixed latency
// RD_LATENCY from acceptance to a one-cycle response pulse. Stores commit at
// the acceptance edge; load data is captured at acceptance and presented in RESP.
// Optional byte-lane stores: MEM_BUS_RESPONDER_BYTE_EN.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int RD_LATENCY  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_bus_responder_if.slave   bus,
  output state_t               dbg_state
);

  localparam int AW       = $clog2(DEPTH_BYTES);
  localparam int WORDS    = DEPTH_BYTES / WORD_BYTES;
  localparam int WIW      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW       = $clog2(RD_LATENCY + 1) + 1;
  localparam int CNT_LOAD = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     rsp_data_q;
  logic            rsp_err_q;

  logic            accept;
  logic            bad_addr;
  logic [AW-1:0]   byte_off;
  logic [WIW-1:0]  word_idx;
  logic [3:0]      store_be;
  logic [3:0]      lane_we;
  logic [31:0]     arr_rdata;

  logic            rsp_on;
  logic            req_ready_c;
  logic [31:0]     rsp_rdata_c;
  logic            rsp_err_c;

  // Only the low address bits index the array; the rest feed the range check
  assign byte_off = bus.req_addr[AW-1:0];
  assign word_idx = WIW'(byte_off >> 2);
  assign bad_addr = is_bad_addr(bus.req_addr, 32'(DEPTH_BYTES));
  assign accept   = bus.req_valid && req_ready_c;

`ifdef MEM_BUS_RESPONDER_BYTE_EN
  assign store_be = bus.req_be;
`else
  assign store_be = 4'hF;
`endif

  // Erroneous requests never touch the array
  assign lane_we = (accept && bus.req_write && !bad_addr) ? store_be : 4'h0;

  mem_byte_array #(
    .WORDS (WORDS),
    .WIW   (WIW)
  ) u_array (
    .clk      (clk),
    .word_idx (word_idx),
    .lane_we  (lane_we),
    .wdata    (bus.req_wdata),
    .rdata    (arr_rdata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (RD_LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latency counter: loaded on acceptance, counts down while waiting
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (accept && (RD_LATENCY > 1)) begin
      cnt_q <= CW'(CNT_LOAD);
    end else if ((state_q == WAIT) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Response registers: load data and error flag captured at acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (accept) begin
      rsp_data_q <= (!bus.req_write && !bad_addr) ? arr_rdata : 32'd0;
      rsp_err_q  <= bad_addr;
    end
  end

  // Outputs: ready only in IDLE outside reset; response fields only in RESP
  always_comb begin
    req_ready_c = (state_q == IDLE) && !reset;
    rsp_on      = (state_q == RESP) && !reset;
    rsp_rdata_c = rsp_on ? rsp_data_q : 32'd0;
    rsp_err_c   = rsp_on && rsp_err_q;
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_on;
  assign bus.rsp_rdata = rsp_rdata_c;
  assign bus.rsp_err   = rsp_err_c;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: two instances (latency 1 and latency 3) driven
// through one request driver, checked against a byte-array reference model.
// Build with MEM_BUS_RESPONDER_BYTE_EN defined to exercise byte-lane stores.
module tb_mem_bus_responder;
  import mem_bus_pkg::*;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam int DEPTH = 256;
`ifdef MEM_BUS_RESPONDER_BYTE_EN
  localparam bit HAS_BE = 1'b1;
`else
  localparam bit HAS_BE = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  mem_bus_responder_if bus0 ();
  mem_bus_responder_if bus1 ();
  state_t dbg0, dbg1;

  int          sel;
  logic        drv_valid;
  logic        drv_write;
  logic [31:0] drv_addr;
  logic [31:0] drv_wdata;
  logic [3:0]  drv_be;

  assign bus0.req_valid = drv_valid && (sel == 0);
  assign bus1.req_valid = drv_valid && (sel == 1);
  assign bus0.req_write = drv_write;
  assign bus1.req_write = drv_write;
  assign bus0.req_addr  = drv_addr;
  assign bus1.req_addr  = drv_addr;
  assign bus0.req_wdata = drv_wdata;
  assign bus1.req_wdata = drv_wdata;
`ifdef MEM_BUS_RESPONDER_BYTE_EN
  assign bus0.req_be = drv_be;
  assign bus1.req_be = drv_be;
`endif

  mem_bus_responder #(.DEPTH_BYTES(DEPTH), .RD_LATENCY(LAT0)) u_dut0 (
    .clk(clk), .reset(rst0), .bus(bus0), .dbg_state(dbg0)
  );
  mem_bus_responder #(.DEPTH_BYTES(DEPTH), .RD_LATENCY(LAT1)) u_dut1 (
    .clk(clk), .reset(rst1), .bus(bus1), .dbg_state(dbg1)
  );

  function automatic logic g_ready(input int s);
    return (s == 1) ? bus1.req_ready : bus0.req_ready;
  endfunction
  function automatic logic g_valid(input int s);
    return (s == 1) ? bus1.rsp_valid : bus0.rsp_valid;
  endfunction
  function automatic logic [31:0] g_rdata(input int s);
    return (s == 1) ? bus1.rsp_rdata : bus0.rsp_rdata;
  endfunction
  function automatic logic g_err(input int s);
    return (s == 1) ? bus1.rsp_err : bus0.rsp_err;
  endfunction

  // ---------------- reference model / scoreboard ----------------
  logic [7:0]  mdl   [2][DEPTH];
  bit          known [2][DEPTH];
  logic [32:0] exp_q [$];
  int          wl0 [$];
  int          wl1 [$];
  int          n_checks = 0;
  int          n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr >= 32'(DEPTH));
  endfunction

  function automatic bit word_known(input int s, input logic [31:0] addr);
    bit k;
    k = 1'b1;
    for (int i = 0; i < 4; i++) k = k && known[s][addr[7:0] + 8'(i)];
    return k;
  endfunction

  // ---------------- driver ----------------
  // One request; checks acceptance, exact response cycle, ready timing and data.
  // With junk set, a conflicting store is presented while the request is in flight.
  task automatic do_req(input int s, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input bit junk, output logic [31:0] got);
    int          lat;
    bit          bad;
    bit          ok;
    logic [31:0] exp_rd;
    logic [32:0] e;
    logic [3:0]  eff_be;
    lat    = (s == 1) ? LAT1 : LAT0;
    bad    = model_bad(addr);
    eff_be = HAS_BE ? be : 4'hF;
    exp_rd = 32'd0;
    if (!wr && !bad)
      for (int i = 0; i < 4; i++) exp_rd[8*i +: 8] = mdl[s][addr[7:0] + 8'(i)];
    exp_q.push_back({bad, exp_rd});
    got = 32'd0;

    sel = s; drv_write = wr; drv_addr = addr; drv_wdata = wdata; drv_be = be;
    drv_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (g_ready(s) === 1'b1) ok = 1'b1;
    end
    check("accept", 32'(ok), 32'd1);
    if (!ok) begin
      drv_valid = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    @(posedge clk);
    #1;
    if (wr && !bad)
      for (int i = 0; i < 4; i++)
        if (eff_be[i]) begin
          mdl[s][addr[7:0] + 8'(i)]   = wdata[8*i +: 8];
          known[s][addr[7:0] + 8'(i)] = 1'b1;
        end
    if (junk) begin
      drv_write = 1'b1;
      drv_wdata = 32'h5555_5555;
      drv_be    = 4'hF;
    end else begin
      drv_valid = 1'b0;
    end
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      check("rsp_valid", 32'(g_valid(s)), 32'(k == lat));
      check("req_ready", 32'(g_ready(s)), 32'(k == lat + 1));
      if (k == lat) begin
        e   = exp_q.pop_front();
        got = g_rdata(s);
        check("rsp_rdata", got, e[31:0]);
        check("rsp_err", 32'(g_err(s)), 32'(e[32]));
        drv_valid = 1'b0;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] got;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    int          r;
    bit          ok;

    drv_valid = 1'b0; drv_write = 1'b0; drv_addr = '0; drv_wdata = '0; drv_be = 4'hF;
    sel = 0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++) known[s][i] = 1'b0;

    // Reset for two cycles; ready stays low throughout
    rst0 = 1'b1; rst1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ready_in_reset0", 32'(bus0.req_ready), 32'd0);
    check("ready_in_reset1", 32'(bus1.req_ready), 32'd0);
    check("valid_in_reset0", 32'(bus0.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    check("ready_after_reset0", 32'(bus0.req_ready), 32'd1);
    check("valid_after_reset0", 32'(bus0.rsp_valid), 32'd0);
    check("rdata_after_reset0", bus0.rsp_rdata, 32'd0);
    check("err_after_reset0", 32'(bus0.rsp_err), 32'd0);
    check("ready_after_reset1", 32'(bus1.req_ready), 32'd1);
    check("valid_after_reset1", 32'(bus1.rsp_valid), 32'd0);

    // Latency 1: store then load back, including the low byte view
    do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, got);
    check("store_rdata_zero", got, 32'd0);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, got);
    check("load_deadbeef", got, 32'hDEAD_BEEF);
    check("byte_view_0x10", 32'(got[7:0]), 32'h0000_00EF);

    // Errors: misaligned, out of range, misaligned store must not write
    do_req(0, 1'b1, 32'hFC, 32'h1234_5678, 4'hF, 1'b0, got);
    do_req(0, 1'b0, 32'h13, 32'h0, 4'hF, 1'b0, got);
    do_req(0, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, got);
    do_req(0, 1'b1, 32'hFD, 32'hFFFF_FFFF, 4'hF, 1'b0, got);
    do_req(0, 1'b1, 32'h1000_00FC, 32'hFFFF_FFFF, 4'hF, 1'b0, got);
    do_req(0, 1'b0, 32'hFC, 32'h0, 4'hF, 1'b0, got);
    check("fc_unchanged", got, 32'h1234_5678);

    // Latency 3: requests presented while busy are ignored
    do_req(1, 1'b1, 32'h80, 32'hCAFE_F00D, 4'hF, 1'b0, got);
    do_req(1, 1'b0, 32'h80, 32'h0, 4'hF, 1'b1, got);
    check("load_cafef00d", got, 32'hCAFE_F00D);
    do_req(1, 1'b0, 32'h80, 32'h0, 4'hF, 1'b0, got);
    check("busy_store_ignored", got, 32'hCAFE_F00D);

    // Reset while waiting: store stays committed, no response is issued
    sel = 1; drv_write = 1'b1; drv_addr = 32'h20; drv_wdata = 32'hA5A5_A5A5; drv_be = 4'hF;
    drv_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (bus1.req_ready === 1'b1) ok = 1'b1;
    end
    check("accept_before_reset", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    rst1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mdl[1][8'h20 + 8'(i)]   = 8'hA5;
      known[1][8'h20 + 8'(i)] = 1'b1;
    end
    @(negedge clk);
    check("no_rsp_in_reset_a", 32'(bus1.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("no_rsp_in_reset_b", 32'(bus1.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    @(negedge clk);
    check("no_rsp_after_reset_a", 32'(bus1.rsp_valid), 32'd0);
    check("ready_after_mid_reset", 32'(bus1.req_ready), 32'd1);
    @(negedge clk);
    check("no_rsp_after_reset_b", 32'(bus1.rsp_valid), 32'd0);
    do_req(1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, got);
    check("load_a5a5a5a5", got, 32'hA5A5_A5A5);

`ifdef MEM_BUS_RESPONDER_BYTE_EN
    // Byte lanes: partial store merges, empty mask is a legal no-op
    do_req(0, 1'b1, 32'h40, 32'h1122_3344, 4'b1111, 1'b0, got);
    do_req(0, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'b0101, 1'b0, got);
    do_req(0, 1'b0, 32'h40, 32'h0, 4'b0000, 1'b0, got);
    check("be_merge", got, 32'h11FF_33FF);
    do_req(0, 1'b1, 32'h40, 32'h0000_0000, 4'b0000, 1'b0, got);
    do_req(0, 1'b0, 32'h40, 32'h0, 4'b1010, 1'b0, got);
    check("be_zero_noop", got, 32'h11FF_33FF);
`endif

    // Randomized traffic on both instances against the model
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 40; n++) begin
        r = $urandom_range(0, 9);
        if (r < 4 || (s == 0 && wl0.size() == 0) || (s == 1 && wl1.size() == 0)) begin
          a  = 32'($urandom_range(0, DEPTH / 4 - 1)) << 2;
          d  = $urandom;
          be = HAS_BE ? 4'($urandom_range(0, 15)) : 4'hF;
          do_req(s, 1'b1, a, d, be, 1'b0, got);
          if (word_known(s, a)) begin
            if (s == 0) wl0.push_back(int'(a));
            else        wl1.push_back(int'(a));
          end
        end else if (r < 8) begin
          if (s == 0) a = 32'(wl0[$urandom_range(0, wl0.size() - 1)]);
          else        a = 32'(wl1[$urandom_range(0, wl1.size() - 1)]);
          do_req(s, 1'b0, a, 32'h0, 4'hF, 1'b0, got);
        end else begin
          if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, DEPTH - 1)) | 32'h1;
          else                           a = 32'(DEPTH) + 32'($urandom_range(0, 4095));
          do_req(s, 1'($urandom_range(0, 1)), a, $urandom, 4'hF, 1'b0, got);
        end
      end
    end

    // Confirm every written word once more after the random phase
    foreach (wl0[i]) do_req(0, 1'b0, 32'(wl0[i]), 32'h0, 4'hF, 1'b0, got);
    foreach (wl1[i]) do_req(1, 1'b0, 32'(wl1[i]), 32'h0, 4'hF, 1'b0, got);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
